// File: rtl/spline_share_sched_pkg.sv
// Shared definitions for the spline share scheduler.
//   COEF_W    : coefficient width (7-bit unsigned)
//   N_TAPS    : taps per channel
//   state_t   : scheduler FSM states
//   COEF_TBL  : [set][tap] coefficient table, set 0 = A, set 1 = B
//   coef_of() : table lookup helper
package spline_pkg;

  localparam int COEF_W = 7;
  localparam int N_TAPS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [COEF_W-1:0] COEF_TBL [2][N_TAPS] = '{
    '{7'd21, 7'd85, 7'd21, 7'd0},
    '{7'd3,  7'd61, 7'd61, 7'd3}
  };

  function automatic logic [COEF_W-1:0] coef_of(input logic set, input logic [1:0] tap);
    return COEF_TBL[set][tap];
  endfunction

endpackage

// File: rtl/spline_share_sched_if.sv
// Sample / result bundle of the spline share scheduler.
//   en         : tick counter run enable
//   din_l/r    : per-channel command samples (DIN_W)
//   dout_l/r   : interpolated results (DIN_W+7)
//   dout_valid : one-cycle pulse on result update
//   busy       : scheduler is computing
// master = sample source / result sink, slave = scheduler.
interface spline_share_sched_if #(
  parameter int DIN_W = 8
);
  localparam int DOUT_W = DIN_W + 7;

  logic              en;
  logic [DIN_W-1:0]  din_l;
  logic [DIN_W-1:0]  din_r;
  logic [DOUT_W-1:0] dout_l;
  logic [DOUT_W-1:0] dout_r;
  logic              dout_valid;
  logic              busy;

  modport master (
    output en, din_l, din_r,
    input  dout_l, dout_r, dout_valid, busy
  );

  modport slave (
    input  en, din_l, din_r,
    output dout_l, dout_r, dout_valid, busy
  );
endinterface

// File: rtl/spline_share_sched_mac.sv
// Shared multiply / accumulate unit.
//   clk, n_rst : clock, async active-low reset
//   step       : perform one MAC operation this cycle
//   load       : 1 = acc <= product, 0 = acc <= acc + product
//   coef       : 7-bit unsigned coefficient
//   sample     : DIN_W unsigned history sample
//   acc        : DOUT_W accumulator (full precision, no wrap possible)
module spline_mac
  import spline_pkg::*;
#(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = DIN_W + 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              step,
  input  logic              load,
  input  logic [COEF_W-1:0] coef,
  input  logic [DIN_W-1:0]  sample,
  output logic [DOUT_W-1:0] acc
);

  logic [DOUT_W-1:0] prod;

  assign prod = DOUT_W'(coef) * DOUT_W'(sample);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc <= '0;
    end else if (step) begin
      acc <= load ? prod : (acc + prod);
    end
  end

endmodule

// File: rtl/spline_share_sched.sv
// Two-channel cubic-spline interpolator sharing one MAC.
// Every TICK_DIV enabled clocks a tick starts an 8-cycle MAC pass
// (left taps 0..3, right taps 0..3) followed by one OUT cycle, so the
// result pulse lands exactly 10 cycles after the tick cycle.
//   clk, n_rst : clock, async active-low reset
//   bus        : spline_share_sched_if.slave (en, din_l/r, dout_l/r,
//                dout_valid, busy)
module spline_share_sched
  import spline_pkg::*;
#(
  parameter int DIN_W    = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  n_rst,
  spline_share_sched_if.slave   bus
);

  localparam int DOUT_W = DIN_W + 7;
  localparam int CNT_W  = $clog2(TICK_DIV);

  // A 10-cycle computation must always finish before the next tick.
  if (TICK_DIV < 10) begin : g_bad_div
    $fatal(1, "spline_share_sched: TICK_DIV must be >= 10");
  end

  logic [CNT_W-1:0]  cnt;
  logic              phase;
  logic              tick;
  logic [DIN_W-1:0]  hist_l [N_TAPS];
  logic [DIN_W-1:0]  hist_r [N_TAPS];

  state_t            state;
  logic [2:0]        mac_idx;
  logic              set_q;
  logic [DOUT_W-1:0] hold_l;
  logic [DOUT_W-1:0] dout_l_q;
  logic [DOUT_W-1:0] dout_r_q;
  logic              dout_valid_q;
  logic              busy_q;

  logic [1:0]        tap;
  logic              mac_step;
  logic              mac_load;
  logic [COEF_W-1:0] mac_coef;
  logic [DIN_W-1:0]  mac_sample;
  logic [DOUT_W-1:0] acc;

  assign tick = bus.en && (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (bus.en) begin
      if (tick) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // History advances only on phase-0 ticks; phase-1 ticks reuse it with set B.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        hist_l[i] <= '0;
        hist_r[i] <= '0;
      end
    end else if (tick && !phase) begin
      for (int i = 0; i < N_TAPS - 1; i++) begin
        hist_l[i] <= hist_l[i+1];
        hist_r[i] <= hist_r[i+1];
      end
      hist_l[N_TAPS-1] <= bus.din_l;
      hist_r[N_TAPS-1] <= bus.din_r;
    end
  end

  // mac_idx[2] selects the channel, mac_idx[1:0] the tap.
  assign tap        = mac_idx[1:0];
  assign mac_step   = (state == S_MAC);
  assign mac_load   = (tap == 2'd0);
  assign mac_coef   = coef_of(set_q, tap);
  assign mac_sample = mac_idx[2] ? hist_r[tap] : hist_l[tap];

  spline_mac #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_mac (
    .clk    (clk),
    .n_rst  (n_rst),
    .step   (mac_step),
    .load   (mac_load),
    .coef   (mac_coef),
    .sample (mac_sample),
    .acc    (acc)
  );

  // state | meaning
  // IDLE  | waiting for a tick
  // MAC   | 8 MAC cycles, left taps then right taps
  // OUT   | acc holds right result; publish both channels
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      mac_idx      <= '0;
      set_q        <= 1'b0;
      hold_l       <= '0;
      dout_l_q     <= '0;
      dout_r_q     <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state   <= S_MAC;
            mac_idx <= '0;
            // Coefficient set is the phase seen in the tick cycle.
            set_q   <= phase;
            busy_q  <= 1'b1;
          end
        end
        S_MAC: begin
          // At index 4 the accumulator still holds the finished left sum.
          if (mac_idx == 3'd4) begin
            hold_l <= acc;
          end
          if (mac_idx == 3'd7) begin
            state <= S_OUT;
          end
          mac_idx <= mac_idx + 1'b1;
        end
        S_OUT: begin
          dout_l_q     <= hold_l;
          dout_r_q     <= acc;
          dout_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout_l     = dout_l_q;
  assign bus.dout_r     = dout_r_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spline_share_sched.sv
// Self-checking bench for spline_share_sched (DIN_W=8, TICK_DIV=10).
// A reference model pushes expected results on every tick; the monitor pops
// and compares them on dout_valid. Scenario tasks add fixed-value checks.
module tb_spline_share_sched;

  localparam int DIN_W    = 8;
  localparam int TICK_DIV = 10;

  logic clk;
  logic n_rst;

  spline_share_sched_if #(.DIN_W(DIN_W)) bus ();

  spline_share_sched #(
    .DIN_W    (DIN_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int l;
    int r;
    int due;
  } exp_t;

  exp_t sb_q[$];

  int tb_coef [2][4] = '{'{21, 85, 21, 0}, '{3, 61, 61, 3}};
  int m_cnt;
  int m_phase;
  int m_hl [4];
  int m_hr [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, evaluated on the same edge the DUT samples inputs.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_cnt   = 0;
      m_phase = 0;
      for (int i = 0; i < 4; i++) begin
        m_hl[i] = 0;
        m_hr[i] = 0;
      end
      sb_q.delete();
    end else begin
      if (bus.en && m_cnt == TICK_DIV - 1) begin
        exp_t e;
        if (m_phase == 0) begin
          for (int i = 0; i < 3; i++) begin
            m_hl[i] = m_hl[i+1];
            m_hr[i] = m_hr[i+1];
          end
          m_hl[3] = int'(bus.din_l);
          m_hr[3] = int'(bus.din_r);
        end
        e.l = 0;
        e.r = 0;
        for (int k = 0; k < 4; k++) begin
          e.l += tb_coef[m_phase][k] * m_hl[k];
          e.r += tb_coef[m_phase][k] * m_hr[k];
        end
        e.due = cyc + 10;
        sb_q.push_back(e);
        m_phase = 1 - m_phase;
      end
      if (bus.en) m_cnt = (m_cnt == TICK_DIV - 1) ? 0 : m_cnt + 1;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (n_rst) begin
      logic exp_busy;
      exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].due - 9) && (cyc <= sb_q[0].due - 1);
      n_cmp++;
      if (bus.busy !== exp_busy) begin
        n_bad++;
        $display("FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy);
      end
      if (bus.dout_valid) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_valid cyc=%0d got l=%0d r=%0d exp none", cyc, bus.dout_l, bus.dout_r);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (bus.dout_l !== e.l || bus.dout_r !== e.r || cyc !== e.due) begin
            n_bad++;
            $display("FAIL sb_result cyc=%0d got l=%0d r=%0d exp l=%0d r=%0d due=%0d",
                     cyc, bus.dout_l, bus.dout_r, e.l, e.r, e.due);
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_missing_valid cyc=%0d got valid=0 exp valid=1", cyc);
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic get_pulse(output int l, output int r);
    bit got;
    got = 0;
    l = -1;
    r = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.dout_valid) begin
        got = 1;
        l = int'(bus.dout_l);
        r = int'(bus.dout_r);
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_timeout got no dout_valid exp one within 40 cycles");
    end
  endtask

  task automatic wait_busy(output int c);
    bit got;
    got = 0;
    c = -1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        got = 1;
        c = cyc;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout got busy=0 exp busy=1 within 30 cycles");
    end
  endtask

  task automatic test_reset();
    bus.en = 1'b1;
    bus.din_l = 8'd77;
    bus.din_r = 8'd99;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (bus.dout_l !== 0) begin n_bad++; $display("FAIL reset_dout_l got=%0d exp=0", bus.dout_l); end
    if (bus.dout_r !== 0) begin n_bad++; $display("FAIL reset_dout_r got=%0d exp=0", bus.dout_r); end
    if (bus.dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_rst = 1'b1;
  endtask

  task automatic test_steady(input int din, input int exp_a, input int exp_b, input int exp_p2);
    int pl [10];
    int pr [10];
    bus.en = 1'b1;
    bus.din_l = DIN_W'(din);
    bus.din_r = DIN_W'(din);
    do_reset();
    for (int p = 0; p < 10; p++) get_pulse(pl[p], pr[p]);
    n_cmp += 2;
    if (pl[0] !== 0 || pr[0] !== 0) begin
      n_bad++; $display("FAIL steady%0d_p1 got l=%0d r=%0d exp 0", din, pl[0], pr[0]);
    end
    if (pl[1] !== exp_p2 || pr[1] !== exp_p2) begin
      n_bad++; $display("FAIL steady%0d_p2 got l=%0d r=%0d exp %0d", din, pl[1], pr[1], exp_p2);
    end
    for (int p = 6; p < 10; p++) begin
      int ex;
      ex = (p % 2 == 0) ? exp_a : exp_b;
      n_cmp++;
      if (pl[p] !== ex || pr[p] !== ex) begin
        n_bad++;
        $display("FAIL steady%0d_p%0d got l=%0d r=%0d exp %0d", din, p + 1, pl[p], pr[p], ex);
      end
    end
  endtask

  task automatic test_impulse();
    int exp_seq [9] = '{0, 3, 21, 61, 85, 61, 21, 3, 0};
    int l;
    int r;
    bus.en = 1'b1;
    bus.din_l = 8'd1;
    bus.din_r = 8'd0;
    do_reset();
    for (int p = 0; p < 9; p++) begin
      get_pulse(l, r);
      if (p == 0) bus.din_l = 8'd0;
      n_cmp++;
      if (l !== exp_seq[p] || r !== 0) begin
        n_bad++;
        $display("FAIL impulse_p%0d got l=%0d r=%0d exp l=%0d r=0", p + 1, l, r, exp_seq[p]);
      end
    end
  endtask

  task automatic test_latency();
    int c1;
    bus.en = 1'b1;
    bus.din_l = 8'd5;
    bus.din_r = 8'd6;
    do_reset();
    wait_busy(c1);
    for (int i = 0; i < 10; i++) begin
      logic eb;
      logic ev;
      if (i > 0) @(negedge clk);
      eb = (i < 9);
      ev = (i == 9);
      n_cmp++;
      if (bus.busy !== eb || bus.dout_valid !== ev) begin
        n_bad++;
        $display("FAIL latency_T+%0d got busy=%b valid=%b exp busy=%b valid=%b",
                 i + 1, bus.busy, bus.dout_valid, eb, ev);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL latency_T+11 got valid=%b exp valid=0", bus.dout_valid);
    end
  endtask

  task automatic test_en_drop();
    int c1;
    int e;
    int seen;
    int l;
    int r;
    bus.en = 1'b1;
    bus.din_l = 8'd10;
    bus.din_r = 8'd20;
    do_reset();
    wait_busy(c1);
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    get_pulse(l, r);
    n_cmp++;
    if (cyc !== c1 + 9) begin
      n_bad++; $display("FAIL en_drop_latency got cyc=%0d exp cyc=%0d", cyc, c1 + 9);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.dout_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL en_drop_hold got %0d pulses exp 0", seen);
    end
    e = cyc;
    bus.en = 1'b1;
    get_pulse(l, r);
    n_cmp++;
    if (cyc - e !== 16) begin
      n_bad++; $display("FAIL en_drop_resume got delay=%0d exp delay=16", cyc - e);
    end
  endtask

  task automatic test_reset_mid_mac();
    int c1;
    int l;
    int r;
    int seen;
    bus.en = 1'b1;
    bus.din_l = 8'd200;
    bus.din_r = 8'd200;
    do_reset();
    get_pulse(l, r);
    get_pulse(l, r);
    wait_busy(c1);
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    #1;
    n_cmp += 4;
    if (bus.dout_l !== 0) begin n_bad++; $display("FAIL midrst_dout_l got=%0d exp=0", bus.dout_l); end
    if (bus.dout_r !== 0) begin n_bad++; $display("FAIL midrst_dout_r got=%0d exp=0", bus.dout_r); end
    if (bus.dout_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b exp=0", bus.dout_valid); end
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.dout_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL midrst_no_valid got %0d pulses exp 0", seen);
    end
    bus.din_l = 8'd50;
    bus.din_r = 8'd50;
    n_rst = 1'b1;
    get_pulse(l, r);
    n_cmp++;
    if (l !== 0 || r !== 0) begin
      n_bad++; $display("FAIL midrst_first got l=%0d r=%0d exp 0", l, r);
    end
    get_pulse(l, r);
    n_cmp++;
    if (l !== 150 || r !== 150) begin
      n_bad++; $display("FAIL midrst_second got l=%0d r=%0d exp 150", l, r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0;
    bus.din_l = '0;
    bus.din_r = '0;
    n_rst = 1'b0;
    test_reset();
    test_steady(100, 12700, 12800, 300);
    test_impulse();
    test_latency();
    test_en_drop();
    test_reset_mid_mac();
    test_steady(255, 32385, 32640, 765);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
